instr_fetch_unit: RTL and testbench

Sits directly downstream of the 128x8 program ROM and upstream of the instruction decoder. Owns the program counter, drives the ROM address, assembles each instruction as a one-byte opcode plus an optional one-byte operand, and presents it to decode over a valid/ready handshake. Branch and jump redirects from execute flush any partially assembled instruction and restart fetch at the target.

---
 rtl/isa_pkg.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: ISA definitions shared by the fetch unit and the instruction decoder.
//   - opcode constants for the instructions that the front end must know about
//   - is_two_byte(): instruction length decode, a pure function of the opcode
//   - fetch_state_e: fetch FSM state encoding
package isa_pkg;

   localparam int unsigned OP_W = 8;

   localparam logic [OP_W-1:0] OP_NOP      = 8'h00;
   localparam logic [OP_W-1:0] OP_BRA      = 8'h20;
   localparam logic [OP_W-1:0] OP_BNE      = 8'h26;
   localparam logic [OP_W-1:0] OP_BEQ      = 8'h27;
   localparam logic [OP_W-1:0] OP_JMP      = 8'h7E;
   localparam logic [OP_W-1:0] OP_LDAA_IMM = 8'h86;
   localparam logic [OP_W-1:0] OP_LDAB_IMM = 8'h88;
   localparam logic [OP_W-1:0] OP_STAA_DIR = 8'h96;
   localparam logic [OP_W-1:0] OP_STAB_DIR = 8'h97;
   localparam logic [OP_W-1:0] OP_LDAA_DIR = 8'hB6;
   localparam logic [OP_W-1:0] OP_LDAB_DIR = 8'hB7;

   typedef enum logic [1:0] {
      StFetchOp,
      StFetchArg,
      StHold
   } fetch_state_e;

   // Opcodes carrying a one-byte operand; everything else (incl. NOP) is single-byte.
   function automatic logic is_two_byte(input logic [OP_W-1:0] opcode);
      logic two;
      case (opcode)
         OP_BRA, OP_BEQ, OP_BNE, OP_JMP,
         OP_LDAA_IMM, OP_LDAB_IMM,
         OP_STAA_DIR, OP_STAB_DIR,
         OP_LDAA_DIR, OP_LDAB_DIR: two = 1'b1;
         default:                  two = 1'b0;
      endcase
      return two;
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads opcode (+ optional operand) bytes from the
// program ROM and presents assembled instructions to decode over valid/ready.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rom_addr          ROM address (the PC register itself)
//   rom_data          combinational ROM read data for rom_addr
//   redirect_valid    one-cycle restart request from execute
//   redirect_addr     restart target
//   inst_valid        assembled instruction available (registered)
//   inst_ready        decoder accepts the instruction
//   inst_opcode       opcode byte
//   inst_operand      operand byte, 0x00 for single-byte opcodes
//   inst_has_operand  opcode is a two-byte instruction
//   inst_pc           address of the opcode byte
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 7,
   parameter int unsigned        DATA_W   = 8,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst_opcode,
   output logic [DATA_W-1:0] inst_operand,
   output logic              inst_has_operand,
   output logic [ADDR_W-1:0] inst_pc
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic [DATA_W-1:0] opcode_q, opcode_d;
   logic [DATA_W-1:0] operand_q, operand_d;
   logic              has_op_q, has_op_d;
   logic              valid_q, valid_d;

   logic              two_byte;
   logic              handshake;
   logic [ADDR_W-1:0] pc_inc;

   assign two_byte  = is_two_byte(rom_data);
   assign handshake = valid_q & inst_ready;
   assign pc_inc    = pc_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetchOp;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a redirect always restarts at the opcode fetch
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = StFetchOp;
      end else begin
         unique case (state_q)
            StFetchOp:  state_d = two_byte ? StFetchArg : StHold;
            StFetchArg: state_d = StHold;
            StHold:     state_d = handshake ? StFetchOp : StHold;
            default:    state_d = StFetchOp;
         endcase
      end
   end

   // Output / datapath next values. All inst_* are registered so they stay
   // frozen in StHold until the decoder takes the instruction.
   always_comb begin
      pc_d      = pc_q;
      inst_pc_d = inst_pc_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      has_op_d  = has_op_q;
      valid_d   = valid_q;
      if (redirect_valid) begin
         // Partial instruction is dropped; stale inst_* are harmless while invalid
         pc_d    = redirect_addr;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StFetchOp: begin
               opcode_d  = rom_data;
               inst_pc_d = pc_q;
               pc_d      = pc_inc;
               has_op_d  = two_byte;
               if (!two_byte) begin
                  operand_d = '0;
               end
               valid_d = ~two_byte;
            end
            StFetchArg: begin
               operand_d = rom_data;
               pc_d      = pc_inc;
               valid_d   = 1'b1;
            end
            StHold: begin
               if (handshake) begin
                  valid_d = 1'b0;
               end
            end
            default: valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         inst_pc_q <= '0;
         opcode_q  <= '0;
         operand_q <= '0;
         has_op_q  <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         inst_pc_q <= inst_pc_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         has_op_q  <= has_op_d;
         valid_q   <= valid_d;
      end
   end

   assign rom_addr         = pc_q;
   assign inst_valid       = valid_q;
   assign inst_opcode      = opcode_q;
   assign inst_operand     = operand_q;
   assign inst_has_operand = has_op_q;
   assign inst_pc          = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus a
// transaction-level model (instruction = bytes at start..start+len-1, presented
// len cycles after its fetch starts) checked every cycle, then a random phase.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       redirect_valid;
   logic [6:0] redirect_addr;
   logic       inst_ready;
   logic [6:0] rom_addr, inst_pc;
   logic [7:0] rom_data, inst_opcode, inst_operand;
   logic       inst_valid, inst_has_operand;

   logic [6:0] rom_addr1, inst_pc1;
   logic [7:0] rom_data1, inst_opcode1, inst_operand1;
   logic       inst_valid1, inst_has_operand1;

   logic [7:0] rom  [128];
   logic [7:0] rom1 [128];

   assign rom_data  = rom[rom_addr];
   assign rom_data1 = rom1[rom_addr1];

   instr_fetch_unit #(.ADDR_W(7), .DATA_W(8), .RESET_PC(7'd0)) dut (
      .clk              (clk),
      .reset            (reset),
      .rom_addr         (rom_addr),
      .rom_data         (rom_data),
      .redirect_valid   (redirect_valid),
      .redirect_addr    (redirect_addr),
      .inst_valid       (inst_valid),
      .inst_ready       (inst_ready),
      .inst_opcode      (inst_opcode),
      .inst_operand     (inst_operand),
      .inst_has_operand (inst_has_operand),
      .inst_pc          (inst_pc)
   );

   // Second instance only for the PC-wrap scenario
   instr_fetch_unit #(.ADDR_W(7), .DATA_W(8), .RESET_PC(7'd127)) dut_wrap (
      .clk              (clk),
      .reset            (reset),
      .rom_addr         (rom_addr1),
      .rom_data         (rom_data1),
      .redirect_valid   (1'b0),
      .redirect_addr    (7'd0),
      .inst_valid       (inst_valid1),
      .inst_ready       (1'b1),
      .inst_opcode      (inst_opcode1),
      .inst_operand     (inst_operand1),
      .inst_has_operand (inst_has_operand1),
      .inst_pc          (inst_pc1)
   );

   int total  = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- model ----------------
   logic [7:0] two_ops [10] = '{8'h20, 8'h27, 8'h26, 8'h7E, 8'h86,
                                8'h88, 8'h96, 8'h97, 8'hB6, 8'hB7};

   function automatic int op_len(input logic [7:0] op);
      for (int i = 0; i < 10; i++) if (two_ops[i] == op) return 2;
      return 1;
   endfunction

   bit         m_valid;
   logic [6:0] m_addr, m_start, m_ipc;
   logic [7:0] m_op, m_arg;
   bit         m_has;
   int         m_len, m_done;

   task automatic m_begin(input logic [6:0] p);
      m_start = p;
      m_addr  = p;
      m_done  = 0;
      m_len   = op_len(rom[p]);
      m_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_begin(7'd0);
         m_op = 8'h00; m_arg = 8'h00; m_has = 1'b0; m_ipc = 7'd0;
      end else if (redirect_valid) begin
         m_begin(redirect_addr);
      end else if (m_valid) begin
         if (inst_ready) m_begin(m_addr);
      end else begin
         m_done++;
         m_addr = m_start + 7'(m_done);
         if (m_done == m_len) begin
            m_valid = 1'b1;
            m_ipc   = m_start;
            m_op    = rom[m_start];
            m_has   = (m_len == 2);
            m_arg   = m_has ? rom[m_start + 7'd1] : 8'h00;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_rom_addr", rom_addr, m_addr);
         check("m_inst_valid", inst_valid, m_valid);
         if (m_valid) begin
            check("m_opcode", inst_opcode, m_op);
            check("m_operand", inst_operand, m_arg);
            check("m_has_operand", inst_has_operand, m_has);
            check("m_inst_pc", inst_pc, m_ipc);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic load_prog1();
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      rom[0] = 8'h86; rom[1] = 8'hAA; rom[2] = 8'h96;
      rom[3] = 8'hF0; rom[4] = 8'h20; rom[5] = 8'hFE;
   endtask

   // Change the ROM only while reset is held so the model sees a static ROM
   task automatic reset_with_prog1();
      reset = 1'b1;
      step(1);
      load_prog1();
      step(1);
      reset = 1'b0;
   endtask

   task automatic exp_inst(input string tag, input logic [7:0] op, input logic [7:0] arg,
                           input logic has, input logic [6:0] pc);
      check({tag, "_valid"}, inst_valid, 1'b1);
      check({tag, "_opcode"}, inst_opcode, op);
      check({tag, "_operand"}, inst_operand, arg);
      check({tag, "_has"}, inst_has_operand, has);
      check({tag, "_pc"}, inst_pc, pc);
   endtask

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_addr = 7'd0; inst_ready = 1'b1;
      load_prog1();
      for (int i = 0; i < 128; i++) rom1[i] = 8'h00;
      rom1[127] = 8'h86; rom1[0] = 8'h55;
      step(1);
      chk_en = 1'b1;
      step(1);

      // Reset values
      check("rst_rom_addr", rom_addr, 7'd0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_opcode", inst_opcode, 8'h00);
      check("rst_operand", inst_operand, 8'h00);
      check("rst_has", inst_has_operand, 1'b0);
      check("rst_pc", inst_pc, 7'd0);
      check("rst_wrap_rom_addr", rom_addr1, 7'd127);

      // Two-byte stream, one instruction every 3 cycles
      reset = 1'b0;
      step(1);
      check("t1_lat_valid", inst_valid, 1'b0);
      check("t1_lat_addr", rom_addr, 7'd1);
      step(1);
      exp_inst("t1_i0", 8'h86, 8'hAA, 1'b1, 7'd0);
      check("t1_addr2", rom_addr, 7'd2);
      // Wrap instance: operand comes from address 0
      check("wrap_valid", inst_valid1, 1'b1);
      check("wrap_opcode", inst_opcode1, 8'h86);
      check("wrap_operand", inst_operand1, 8'h55);
      check("wrap_pc", inst_pc1, 7'd127);
      check("wrap_rom_addr", rom_addr1, 7'd1);
      step(3);
      exp_inst("t1_i1", 8'h96, 8'hF0, 1'b1, 7'd2);
      step(3);
      exp_inst("t1_i2", 8'h20, 8'hFE, 1'b1, 7'd4);
      check("t1_addr6", rom_addr, 7'd6);

      // Single-byte run, one instruction every 2 cycles
      reset = 1'b1;
      step(1);
      for (int i = 0; i < 128; i++) rom[i] = 8'h00;
      step(1);
      reset = 1'b0;
      step(1);
      exp_inst("t2_i0", 8'h00, 8'h00, 1'b0, 7'd0);
      step(1);
      check("t2_gap", inst_valid, 1'b0);
      step(1);
      exp_inst("t2_i1", 8'h00, 8'h00, 1'b0, 7'd1);
      step(2);
      exp_inst("t2_i2", 8'h00, 8'h00, 1'b0, 7'd2);

      // Backpressure
      inst_ready = 1'b0;
      reset_with_prog1();
      step(2);
      exp_inst("t3_hold0", 8'h86, 8'hAA, 1'b1, 7'd0);
      step(5);
      exp_inst("t3_hold5", 8'h86, 8'hAA, 1'b1, 7'd0);
      check("t3_addr_held", rom_addr, 7'd2);
      inst_ready = 1'b1;
      step(1);
      check("t3_after_hs_valid", inst_valid, 1'b0);
      check("t3_after_hs_addr", rom_addr, 7'd2);
      step(2);
      exp_inst("t3_next", 8'h96, 8'hF0, 1'b1, 7'd2);

      // Redirect during the operand fetch
      reset_with_prog1();
      step(1);
      redirect_valid = 1'b1; redirect_addr = 7'd4;
      step(1);
      redirect_valid = 1'b0;
      check("t4_redir_valid", inst_valid, 1'b0);
      check("t4_redir_addr", rom_addr, 7'd4);
      step(1);
      check("t4_no_stale", inst_valid, 1'b0);
      step(1);
      exp_inst("t4_target", 8'h20, 8'hFE, 1'b1, 7'd4);
      // Redirect coinciding with a handshake
      redirect_valid = 1'b1; redirect_addr = 7'd2;
      step(1);
      redirect_valid = 1'b0;
      check("t4b_valid", inst_valid, 1'b0);
      check("t4b_addr", rom_addr, 7'd2);
      step(2);
      exp_inst("t4b_target", 8'h96, 8'hF0, 1'b1, 7'd2);

      // Reset while holding with inst_ready=0
      inst_ready = 1'b0;
      reset = 1'b1;
      step(1);
      check("t6_valid", inst_valid, 1'b0);
      check("t6_addr", rom_addr, 7'd0);
      check("t6_opcode", inst_opcode, 8'h00);
      reset = 1'b0;
      step(2);
      exp_inst("t6_first", 8'h86, 8'hAA, 1'b1, 7'd0);

      // Random program with random backpressure, redirects and resets
      reset = 1'b1;
      step(1);
      for (int i = 0; i < 128; i++)
         rom[i] = ($urandom_range(1, 0) == 1) ? two_ops[$urandom_range(9, 0)]
                                              : 8'($urandom);
      step(1);
      reset = 1'b0;
      for (int c = 0; c < 600; c++) begin
         inst_ready     = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(15, 0) == 0);
         redirect_addr  = 7'($urandom);
         reset          = ($urandom_range(79, 0) == 0);
         step(1);
      end
      reset = 1'b0; redirect_valid = 1'b0;
      step(1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
